// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. FIFO-buffered long-latency results.
// Optional macro WB_ARB_BYPASS_EN writes a long-latency result straight through when the port is idle.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_d,
  input  logic [31:0] wb_val,
  output logic        wb_stall,
  input  logic        ll_valid,
  input  logic [4:0]  ll_d,
  input  logic [31:0] ll_val,
  output logic        ll_ready,
  output logic        rf_we,
  output logic [4:0]  rf_d,
  output logic [31:0] rf_val,
  output logic [31:0] pend_mask
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = 8;

  typedef enum logic [0:0] {StPipe, StDrain} state_e;

  state_e         r_state, w_state_d;
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count, w_count_d;
  logic [SW-1:0]  r_starve, w_starve_d;
  logic [4:0]     r_mem_d   [DEPTH];
  logic [31:0]    r_mem_val [DEPTH];

  logic           r_rf_we, w_rf_we_d;
  logic [4:0]     r_rf_d, w_rf_d_d;
  logic [31:0]    r_rf_val, w_rf_val_d;

  logic           w_empty, w_full, w_starved;
  logic           w_wb_req, w_conflict, w_force;
  logic           w_grant_ll, w_grant_wb;
  logic           w_push, w_enq, w_pop, w_bypass;
  logic [31:0]    w_pend;
  logic [PW-1:0]  w_off;

  // Slot i holds a live entry when its distance from the read pointer is below the count.
  always_comb begin
    w_pend = '0;
    w_off  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if (CW'(w_off) < r_count) begin
        w_pend[r_mem_d[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == CW'(DEPTH));
    w_starved  = (r_starve == SW'(STARVE_LIMIT));
    w_wb_req   = wb_valid && (wb_d != 5'd0);
    w_conflict = w_wb_req && w_pend[wb_d];
    w_force    = w_conflict || w_full || w_starved;
    w_grant_ll = !w_empty && ((r_state == StDrain) || !w_wb_req || w_force);
    w_grant_wb = w_wb_req && !w_grant_ll;
    w_pop      = w_grant_ll;
    w_push     = ll_valid && !w_full;
`ifdef WB_ARB_BYPASS_EN
    w_bypass   = w_empty && !w_wb_req && w_push && (ll_d != 5'd0);
`else
    w_bypass   = 1'b0;
`endif
    w_enq      = w_push && (ll_d != 5'd0) && !w_bypass;
  end

  always_comb begin
    w_count_d = r_count + CW'(w_enq) - CW'(w_pop);

    w_starve_d = r_starve;
    if (w_empty || w_pop) begin
      w_starve_d = '0;
    end else if (!w_starved) begin
      w_starve_d = r_starve + 1'b1;
    end

    w_state_d = r_state;
    unique case (r_state)
      StPipe:  if (w_grant_ll && w_wb_req && w_force) w_state_d = StDrain;
      StDrain: w_state_d = StDrain;
      default: w_state_d = StPipe;
    endcase
    // Leaving the FIFO empty always ends a drain, even one that would start this cycle.
    if (w_count_d == '0) begin
      w_state_d = StPipe;
    end

    w_rf_we_d  = w_grant_ll || w_grant_wb || w_bypass;
    w_rf_d_d   = r_rf_d;
    w_rf_val_d = r_rf_val;
    if (w_grant_ll) begin
      w_rf_d_d   = r_mem_d[r_rd_ptr];
      w_rf_val_d = r_mem_val[r_rd_ptr];
    end else if (w_grant_wb) begin
      w_rf_d_d   = wb_d;
      w_rf_val_d = wb_val;
    end else if (w_bypass) begin
      w_rf_d_d   = ll_d;
      w_rf_val_d = ll_val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StPipe;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_rf_we  <= 1'b0;
      r_rf_d   <= '0;
      r_rf_val <= '0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_starve <= w_starve_d;
      r_rf_we  <= w_rf_we_d;
      r_rf_d   <= w_rf_d_d;
      r_rf_val <= w_rf_val_d;
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem_d[r_wr_ptr]   <= ll_d;
      r_mem_val[r_wr_ptr] <= ll_val;
    end
  end

  assign wb_stall  = w_wb_req && w_grant_ll;
  assign ll_ready  = !w_full;
  assign rf_we     = r_rf_we;
  assign rf_d      = r_rf_d;
  assign rf_val    = r_rf_val;
  assign pend_mask = w_pend;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus reset sequences.
// Honours WB_ARB_BYPASS_EN for the bypass rows.
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_valid, ll_valid;
  logic [4:0]  wb_d, ll_d;
  logic [31:0] wb_val, ll_val;
  logic        wb_stall, ll_ready, rf_we;
  logic [4:0]  rf_d;
  logic [31:0] rf_val, pend_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wb_valid  (wb_valid),
    .wb_d      (wb_d),
    .wb_val    (wb_val),
    .wb_stall  (wb_stall),
    .ll_valid  (ll_valid),
    .ll_d      (ll_d),
    .ll_val    (ll_val),
    .ll_ready  (ll_ready),
    .rf_we     (rf_we),
    .rf_d      (rf_d),
    .rf_val    (rf_val),
    .pend_mask (pend_mask)
  );

  typedef struct {
    logic        wv;
    logic [4:0]  wd;
    logic [31:0] wval;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] lval;
    logic        stall;
    logic        ready;
    logic [31:0] pend;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] rval;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0007;
  localparam logic [31:0] C = 32'hCCCC_0009;
  localparam logic [31:0] D = 32'hDDDD_0009;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [4:0] wd, input logic [31:0] wval,
                     input logic lv, input logic [4:0] ld, input logic [31:0] lval,
                     input logic stall, input logic ready, input logic [31:0] pend,
                     input logic rwe, input logic [4:0] rd, input logic [31:0] rval);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wval = wval; v.lv = lv; v.ld = ld; v.lval = lval;
    v.stall = stall; v.ready = ready; v.pend = pend; v.rwe = rwe; v.rd = rd; v.rval = rval;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wv, input logic [4:0] wd, input logic [31:0] wval,
                       input logic lv, input logic [4:0] ld, input logic [31:0] lval);
    wb_valid = wv; wb_d = wd; wb_val = wval;
    ll_valid = lv; ll_d = ld; ll_val = lval;
  endtask

  function automatic logic [31:0] bit_of(input int i);
    logic [31:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_d", 32'(rf_d), 32'd0);
    chk("reset rf_val", rf_val, 32'd0);
    chk("reset ll_ready", 32'(ll_ready), 32'd1);
    chk("reset pend_mask", pend_mask, 32'd0);
    chk("reset wb_stall", 32'(wb_stall), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Mid-operation asynchronous reset flushes queued entries.
    @(negedge clock);
    drive(1'b1, 5'd5, A, 1'b1, 5'd20, 32'h1);
    @(negedge clock);
    drive(1'b1, 5'd5, A, 1'b1, 5'd21, 32'h2);
    @(negedge clock);
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    chk("pre-reset pend_mask", pend_mask, bit_of(20) | bit_of(21));
    chk("pre-reset rf_we", 32'(rf_we), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset rf_we", 32'(rf_we), 32'd0);
    chk("async reset ll_ready", 32'(ll_ready), 32'd1);
    chk("async reset pend_mask", pend_mask, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post-reset rf_we", 32'(rf_we), 32'd0);
    chk("post-reset pend_mask", pend_mask, 32'd0);

    // r0 discard
    add(1, 5'd0, 32'h5555, 1, 5'd0, 32'h6666, 0, 1, 32'd0, 0, 5'd0, 32'd0);
    add(0, 5'd0, 32'd0,    0, 5'd0, 32'd0,    0, 1, 32'd0, 0, 5'd0, 32'd0);
    // Priority: one push to r7, pipeline wins for 8 cycles, then starve forces the pop
    add(1, 5'd5, A, 1, 5'd7, B, 0, 1, 32'd0, 1, 5'd5, A);
    for (int i = 0; i < 8; i++) add(1, 5'd5, A, 0, 5'd0, '0, 0, 1, bit_of(7), 1, 5'd5, A);
    add(1, 5'd5, A, 0, 5'd0, '0, 1, 1, bit_of(7), 1, 5'd7, B);
    add(1, 5'd5, A, 0, 5'd0, '0, 0, 1, 32'd0,     1, 5'd5, A);
    // WAW on r9
    add(1, 5'd5, A, 1, 5'd9, C,   0, 1, 32'd0,     1, 5'd5, A);
    add(1, 5'd9, D, 0, 5'd0, '0,  1, 1, bit_of(9), 1, 5'd9, C);
    add(1, 5'd9, D, 0, 5'd0, '0,  0, 1, 32'd0,     1, 5'd9, D);
    // Full: four pushes behind a busy pipeline, then a forced in-order drain
    add(1, 5'd5, A, 1, 5'd10, 32'hE0, 0, 1, 32'd0, 1, 5'd5, A);
    add(1, 5'd5, A, 1, 5'd11, 32'hE1, 0, 1, bit_of(10), 1, 5'd5, A);
    add(1, 5'd5, A, 1, 5'd12, 32'hE2, 0, 1, bit_of(10) | bit_of(11), 1, 5'd5, A);
    add(1, 5'd5, A, 1, 5'd13, 32'hE3, 0, 1, bit_of(10) | bit_of(11) | bit_of(12), 1, 5'd5, A);
    add(1, 5'd5, A, 1, 5'd14, 32'hE4, 1, 0,
        bit_of(10) | bit_of(11) | bit_of(12) | bit_of(13), 1, 5'd10, 32'hE0);
    add(1, 5'd5, A, 0, 5'd0, '0, 1, 1, bit_of(11) | bit_of(12) | bit_of(13), 1, 5'd11, 32'hE1);
    add(1, 5'd5, A, 0, 5'd0, '0, 1, 1, bit_of(12) | bit_of(13), 1, 5'd12, 32'hE2);
    add(1, 5'd5, A, 0, 5'd0, '0, 1, 1, bit_of(13), 1, 5'd13, 32'hE3);
    add(1, 5'd5, A, 0, 5'd0, '0, 0, 1, 32'd0, 1, 5'd5, A);
    // Idle-port long-latency write
`ifdef WB_ARB_BYPASS_EN
    add(0, 5'd0, '0, 1, 5'd3, 32'h1234, 0, 1, 32'd0, 1, 5'd3, 32'h1234);
    add(0, 5'd0, '0, 0, 5'd0, '0,       0, 1, 32'd0, 0, 5'd0, 32'd0);
`else
    add(0, 5'd0, '0, 1, 5'd3, 32'h1234, 0, 1, 32'd0,     0, 5'd0, 32'd0);
    add(0, 5'd0, '0, 0, 5'd0, '0,       0, 1, bit_of(3), 1, 5'd3, 32'h1234);
`endif
    add(0, 5'd0, '0, 0, 5'd0, '0, 0, 1, 32'd0, 0, 5'd0, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].wv, vecs[i].wd, vecs[i].wval, vecs[i].lv, vecs[i].ld, vecs[i].lval);
      #1;
      chk($sformatf("row%0d wb_stall", i), 32'(wb_stall), 32'(vecs[i].stall));
      chk($sformatf("row%0d ll_ready", i), 32'(ll_ready), 32'(vecs[i].ready));
      chk($sformatf("row%0d pend_mask", i), pend_mask, vecs[i].pend);
      @(posedge clock);
      #1;
      chk($sformatf("row%0d rf_we", i), 32'(rf_we), 32'(vecs[i].rwe));
      if (vecs[i].rwe) begin
        chk($sformatf("row%0d rf_d", i), 32'(rf_d), 32'(vecs[i].rd));
        chk($sformatf("row%0d rf_val", i), rf_val, vecs[i].rval);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency result source (multiply/divide or data-memory miss return). Long-latency results are buffered in a small FIFO. The pipeline has priority except when the FIFO must drain. The block stalls writeback when it loses arbitration and exports a pending-destination mask to the hazard unit. It sits between the writeback stage outputs (`rdval`, `rwe`, `d`) and the register file write port.

## Interface
- `DEPTH`, 4: FIFO entries for long-latency results; power of two, 2..16.
- `STARVE_LIMIT`, 8: consecutive cycles a non-empty FIFO may be denied before a forced drain; 1..255.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: pipeline writeback request (writeback `rwe`).
- `wb_d` in 5: pipeline destination register.
- `wb_val` in 32: pipeline write data.
- `wb_stall` out 1: combinational; pipeline must hold its writeback this cycle.
- `ll_valid` in 1: long-latency result offered.
- `ll_d` in 5: long-latency destination register.
- `ll_val` in 32: long-latency data.
- `ll_ready` out 1: FIFO can accept; registered-count based.
- `rf_we` out 1: register-file write enable, registered.
- `rf_d` out 5: register-file write address, registered.
- `rf_val` out 32: register-file write data, registered.
- `pend_mask` out 32: bit i set when any FIFO entry targets register i.

## Operation
- `wb_req` = `wb_valid` && `wb_d` != 0. A `wb_valid` with `wb_d` = 0 is consumed silently: no write, no stall.
- Push occurs when `ll_valid` && `ll_ready`. A push with `ll_d` = 0 is accepted and discarded (not enqueued).
- `ll_ready` = count < `DEPTH`, using the registered count. A simultaneous pop does not free a slot in the same cycle.
- `conflict` = `wb_req` && `pend_mask[wb_d]`. This is a WAW case: the older FIFO write must land first.
- States:
  - PIPE: normal operation.
  - DRAIN: forced FIFO drain.
- `grant_ll` = FIFO non-empty && (state == DRAIN || !`wb_req` || `conflict` || count == `DEPTH` || starve == `STARVE_LIMIT`).
- `grant_wb` = `wb_req` && !`grant_ll`.
- `wb_stall` = `wb_req` && `grant_ll`.
- Pop occurs on `grant_ll`.
- Transitions:
  - PIPE→DRAIN when `grant_ll` fires because of `conflict`, full, or starve while `wb_req` is high.
  - DRAIN→PIPE when the FIFO becomes empty at the edge (count 1, pop, no enqueue).
  - DRAIN with continuing pushes stays in DRAIN.
- Starve counter:
  - Increments (saturating at `STARVE_LIMIT`) each cycle the FIFO is non-empty and not popped.
  - Clears on pop or when the FIFO is empty.
- `pend_mask` is the combinational OR of one-hot decodes of all valid entry destinations.
- Reset mid-operation flushes the FIFO contents. Pending long-latency results are lost; upstream is reset together.

## Timing
- Reset values:
  - `rf_we` = 0, `rf_d` = 0, `rf_val` = 0.
  - FIFO empty, state PIPE, starve 0.
  - `pend_mask` = 0, `ll_ready` = 1, `wb_stall` = 0.
- The granted source is registered onto `rf_*` at the next edge. `rf_we` = 0 in cycles with no grant.
- Pipeline latency is 1 cycle, from `wb_req` granted to `rf_we`.
- Long-latency latency is at least 2 cycles: push at edge N, earliest grant in cycle N+1, `rf_we` after edge N+1.
- While `wb_stall` is high, the pipeline holds `wb_d`/`wb_val` stable. The request is re-evaluated every cycle.
- The FIFO is a circular buffer with wrap-around pointers of log2(`DEPTH`) bits plus a count register.

## Configuration
- `WB_ARB_BYPASS_EN`:
  - Defined: when the FIFO is empty, `wb_req` = 0, and a push with `ll_d` != 0 occurs, the result is written directly to `rf_*` at that edge. It is not enqueued, so latency is 1 cycle.
  - Undefined: every accepted long-latency result goes through the FIFO.

## Test plan
- Reset: assert `reset_n` = 0 asynchronously mid-cycle → `rf_we` = 0, `ll_ready` = 1, `pend_mask` = 0 immediately.
- Priority:
  - Stimulus: `wb_req` (`wb_d` = 5, `wb_val` = 0xAAAA0001) held every cycle, with one long-latency push to `ll_d` = 7.
  - Response: no stall for 8 cycles, then starve forces a pop. `wb_stall` = 1 for one cycle, `rf_d` = 7 is written, then `rf_d` = 5 resumes.
- WAW:
  - Stimulus: enqueue `ll_d` = 9, then `wb_req` with `wb_d` = 9.
  - Response: `wb_stall` = 1, FIFO write to r9 lands first, pipeline write to r9 follows on the next cycle.
- Full: 4 pushes with no pops (`wb_req` held) → `ll_ready` = 0 after the 4th. Next cycle DRAIN empties all 4 in order while `wb_stall` = 1 throughout, then returns to PIPE.
- r0 discard: `wb_d` = 0 and `ll_d` = 0 pushes → `rf_we` never asserts, `pend_mask` stays 0, `wb_stall` stays 0.
- Bypass: with an empty FIFO and idle pipeline, push `ll_d` = 3, `ll_val` = 0x1234 → with `WB_ARB_BYPASS_EN`, `rf_we` = 1 one cycle later; without it, two cycles later.
